// File: rtl/tinycpu_mon_pkg.sv
// Shared definitions for the tinycpu retire monitor: halt cause codes and trace layout.
// Trace entry is {pc, ra, rb, rm}; field offsets below are in units of DATA_W from the LSB.
package tinycpu_mon_pkg;

    typedef enum logic [1:0] {
        HALT_NONE = 2'b00,
        HALT_LOOP = 2'b01,
        HALT_WDOG = 2'b10
    } halt_cause_e;

    localparam int TRACE_RM_FIELD = 0;
    localparam int TRACE_RB_FIELD = 1;
    localparam int TRACE_RA_FIELD = 2;
    localparam int TRACE_PC_FIELD = 3;

    function automatic int trace_lsb(input int field, input int data_w);
        return field * data_w;
    endfunction

    function automatic int trace_width(input int addr_w, input int data_w);
        return addr_w + 3 * data_w;
    endfunction

endpackage

// File: rtl/tinycpu_mon_fifo.sv
// Generic synchronous FIFO for trace storage, push/full write side and valid/ready read side.
// Latency: one cycle from push into an empty FIFO to out_valid.
// Backpressure: out_data holds while out_ready=0; a push while full is accepted only alongside a pop.
module tinycpu_mon_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    // The extra MSB on each pointer separates full from empty when the indices match.
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             empty;
    logic             pop;
    logic             wr_en;

    assign empty     = (wptr == rptr);
    assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign out_valid = !empty;
    assign out_data  = mem[rptr[AW-1:0]];
    assign pop       = out_valid && out_ready;
    assign wr_en     = push && (!full || pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/tinycpu_monitor.sv
// Retire monitor: traces every retire into a FIFO and halts on self-loops (or idle watchdog
// when TINYCPU_MON_WATCHDOG_EN is defined). Latency: halt and trace_valid one edge after the retire.
// Backpressure: trace_ready stalls the FIFO; retires arriving while it is full are dropped and counted.
module tinycpu_monitor
    import tinycpu_mon_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int LOOP_COUNT  = 1,
    parameter int WDOG_CYCLES = 100000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       retire_valid,
    input  logic [ADDR_W-1:0]          retire_pc,
    input  logic                       retire_jump,
    input  logic [ADDR_W-1:0]          retire_target,
    input  logic [DATA_W-1:0]          retire_ra,
    input  logic [DATA_W-1:0]          retire_rb,
    input  logic [DATA_W-1:0]          retire_rm,
    output logic                       trace_valid,
    input  logic                       trace_ready,
    output logic [ADDR_W+3*DATA_W-1:0] trace_data,
    output logic                       halted,
    output logic [1:0]                 halt_cause,
    output logic [7:0]                 drop_count
);

    localparam int TW     = trace_width(ADDR_W, DATA_W);
    localparam int PC_LSB = trace_lsb(TRACE_PC_FIELD, DATA_W);
    localparam int RA_LSB = trace_lsb(TRACE_RA_FIELD, DATA_W);
    localparam int RB_LSB = trace_lsb(TRACE_RB_FIELD, DATA_W);
    localparam int RM_LSB = trace_lsb(TRACE_RM_FIELD, DATA_W);
    localparam int LCW    = $clog2(LOOP_COUNT + 1);
    localparam logic [LCW-1:0] LOOP_LAST = LCW'(LOOP_COUNT - 1);
    localparam logic [LCW-1:0] LOOP_ONE  = 1;

    logic            accept;
    logic            self_jump;
    logic            loop_hit;
    logic            wdog_hit;
    logic            fifo_full;
    logic            drop;
    logic [TW-1:0]   push_data;
    logic [LCW-1:0]  loop_cnt;
    halt_cause_e     cause_q;

    assign accept    = retire_valid && !halted;
    assign self_jump = retire_jump && (retire_target == retire_pc);
    assign loop_hit  = accept && self_jump && (loop_cnt == LOOP_LAST);
    assign drop      = accept && fifo_full && !(trace_valid && trace_ready);

    always_comb begin
        push_data                     = '0;
        push_data[PC_LSB +: ADDR_W]   = retire_pc;
        push_data[RA_LSB +: DATA_W]   = retire_ra;
        push_data[RB_LSB +: DATA_W]   = retire_rb;
        push_data[RM_LSB +: DATA_W]   = retire_rm;
    end

    tinycpu_mon_fifo #(
        .WIDTH (TW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (push_data),
        .full      (fifo_full),
        .out_valid (trace_valid),
        .out_ready (trace_ready),
        .out_data  (trace_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            loop_cnt <= '0;
        end else if (accept) begin
            if (!self_jump) begin
                loop_cnt <= '0;
            end else if (!loop_hit) begin
                loop_cnt <= loop_cnt + LOOP_ONE;
            end
        end
    end

`ifdef TINYCPU_MON_WATCHDOG_EN
    localparam int WCW = $clog2(WDOG_CYCLES);
    localparam logic [WCW-1:0] WDOG_LAST = WCW'(WDOG_CYCLES - 1);
    localparam logic [WCW-1:0] WDOG_ONE  = 1;

    logic [WCW-1:0] idle_cnt;

    assign wdog_hit = !halted && !retire_valid && (idle_cnt == WDOG_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (!halted) begin
            if (retire_valid) begin
                idle_cnt <= '0;
            end else if (!wdog_hit) begin
                idle_cnt <= idle_cnt + WDOG_ONE;
            end
        end
    end
`else
    assign wdog_hit = 1'b0;
`endif

    // First cause wins; the loop check outranks the watchdog on a same-edge tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halted  <= 1'b0;
            cause_q <= HALT_NONE;
        end else if (!halted) begin
            if (loop_hit) begin
                halted  <= 1'b1;
                cause_q <= HALT_LOOP;
            end else if (wdog_hit) begin
                halted  <= 1'b1;
                cause_q <= HALT_WDOG;
            end
        end
    end

    assign halt_cause = cause_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_tinycpu_monitor.sv
// Directed bench: u_l1 (LOOP_COUNT=1, WDOG_CYCLES=16) and u_l3 (LOOP_COUNT=3) share stimulus.
// Watchdog checks follow TINYCPU_MON_WATCHDOG_EN.
module tb_tinycpu_monitor;

    logic        clk;
    logic        reset;
    logic        retire_valid;
    logic [7:0]  retire_pc;
    logic        retire_jump;
    logic [7:0]  retire_target;
    logic [7:0]  retire_ra;
    logic [7:0]  retire_rb;
    logic [7:0]  retire_rm;
    logic        trace_ready;

    logic        a_valid, b_valid;
    logic [31:0] a_data, b_data;
    logic        a_halted, b_halted;
    logic [1:0]  a_cause, b_cause;
    logic [7:0]  a_drop, b_drop;

    int checks;
    int failures;

    tinycpu_monitor #(.LOOP_COUNT(1), .WDOG_CYCLES(16)) u_l1 (
        .clk(clk), .reset(reset), .retire_valid(retire_valid), .retire_pc(retire_pc),
        .retire_jump(retire_jump), .retire_target(retire_target), .retire_ra(retire_ra),
        .retire_rb(retire_rb), .retire_rm(retire_rm), .trace_valid(a_valid),
        .trace_ready(trace_ready), .trace_data(a_data), .halted(a_halted),
        .halt_cause(a_cause), .drop_count(a_drop)
    );

    tinycpu_monitor #(.LOOP_COUNT(3)) u_l3 (
        .clk(clk), .reset(reset), .retire_valid(retire_valid), .retire_pc(retire_pc),
        .retire_jump(retire_jump), .retire_target(retire_target), .retire_ra(retire_ra),
        .retire_rb(retire_rb), .retire_rm(retire_rm), .trace_valid(b_valid),
        .trace_ready(trace_ready), .trace_data(b_data), .halted(b_halted),
        .halt_cause(b_cause), .drop_count(b_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Register values are derived from pc so the expected entry depends on pc alone.
    function automatic logic [31:0] ent(input logic [7:0] pc);
        return {pc, pc, ~pc, pc ^ 8'h5A};
    endfunction

    task automatic retire(input logic [7:0] pc, input logic jmp, input logic [7:0] tgt);
        retire_valid  = 1'b1;
        retire_pc     = pc;
        retire_jump   = jmp;
        retire_target = tgt;
        retire_ra     = pc;
        retire_rb     = ~pc;
        retire_rm     = pc ^ 8'h5A;
        tick();
        retire_valid  = 1'b0;
        retire_jump   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] pc;
        checks        = 0;
        failures      = 0;
        reset         = 1'b0;
        retire_valid  = 1'b0;
        retire_pc     = '0;
        retire_jump   = 1'b0;
        retire_target = '0;
        retire_ra     = '0;
        retire_rb     = '0;
        retire_rm     = '0;
        trace_ready   = 1'b0;

        #2;
        check("rst_valid", b_valid, 1'b0);
        check("rst_halted", b_halted, 1'b0);
        check("rst_cause", b_cause, 2'b00);
        check("rst_drop", b_drop, 8'd0);
        tick();
        tick();
        reset = 1'b1;

        // Single self-jump halts u_l1 and is still traced; later retires are ignored.
        retire(8'd5, 1'b1, 8'd5);
        check("l1_halted", a_halted, 1'b1);
        check("l1_cause", a_cause, 2'b01);
        check("l1_valid", a_valid, 1'b1);
        check("l1_data", a_data, ent(8'd5));
        retire(8'd6, 1'b0, 8'd0);
        retire(8'd7, 1'b1, 8'd7);
        trace_ready = 1'b1;
        tick();
        check("l1_ignored", a_valid, 1'b0);
        check("l1_drop", a_drop, 8'd0);
        check("l1_cause_hold", a_cause, 2'b01);

        // LOOP_COUNT=3: a broken run restarts the count.
        do_reset();
        trace_ready = 1'b1;
        retire(8'd10, 1'b1, 8'd10);
        retire(8'd10, 1'b1, 8'd10);
        check("l3_run1", b_halted, 1'b0);
        retire(8'd11, 1'b0, 8'd0);
        retire(8'd12, 1'b1, 8'd12);
        check("l3_run2_1", b_halted, 1'b0);
        retire(8'd12, 1'b1, 8'd12);
        check("l3_run2_2", b_halted, 1'b0);
        retire(8'd12, 1'b1, 8'd12);
        check("l3_run2_3", b_halted, 1'b1);
        check("l3_cause", b_cause, 2'b01);

        // Ten retires into a stalled 8-deep FIFO: two drops, then in-order drain.
        do_reset();
        trace_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pc = 8'h20 + 8'(i);
            retire(pc, 1'b0, 8'd0);
        end
        check("full_drop", b_drop, 8'd2);
        check("full_valid", b_valid, 1'b1);
        check("full_head", b_data, ent(8'h20));
        tick();
        tick();
        check("stall_stable", b_data, ent(8'h20));
        trace_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pc = 8'h20 + 8'(i);
            check("drain_valid", b_valid, 1'b1);
            check("drain_data", b_data, ent(pc));
            tick();
        end
        check("drain_empty", b_valid, 1'b0);
        trace_ready = 1'b0;

        // Full FIFO with push and pop together: no drop, occupancy stays at depth.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            pc = 8'h40 + 8'(i);
            retire(pc, 1'b0, 8'd0);
        end
        check("pp_fill_drop", b_drop, 8'd0);
        trace_ready = 1'b1;
        retire(8'h48, 1'b0, 8'd0);
        trace_ready = 1'b0;
        check("pp_nodrop", b_drop, 8'd0);
        retire(8'h49, 1'b0, 8'd0);
        check("pp_still_full", b_drop, 8'd1);
        trace_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pc = 8'h41 + 8'(i);
            check("pp_drain", b_data, ent(pc));
            tick();
        end
        check("pp_empty", b_valid, 1'b0);
        trace_ready = 1'b0;

        // Reset pulse with four entries queued and u_l1 halted.
        retire(8'h60, 1'b0, 8'd0);
        retire(8'h61, 1'b0, 8'd0);
        retire(8'h62, 1'b0, 8'd0);
        retire(8'h63, 1'b1, 8'h63);
        check("pre_rst_halt", a_halted, 1'b1);
        check("pre_rst_valid", b_valid, 1'b1);
        check("pre_rst_drop", b_drop, 8'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_valid", b_valid, 1'b0);
        check("mid_rst_drop", b_drop, 8'd0);
        check("mid_rst_halted", a_halted, 1'b0);
        check("mid_rst_cause", a_cause, 2'b00);
        @(posedge clk);
        #1;
        reset = 1'b1;
        retire(8'h70, 1'b0, 8'd0);
        check("post_rst_b", b_data, ent(8'h70));
        check("post_rst_a_valid", a_valid, 1'b1);
        check("post_rst_a", a_data, ent(8'h70));
        trace_ready = 1'b1;

        do_reset();
`ifdef TINYCPU_MON_WATCHDOG_EN
        repeat (15) tick();
        check("wdog_15", a_halted, 1'b0);
        retire(8'h80, 1'b0, 8'd0);
        repeat (15) tick();
        check("wdog_restart", a_halted, 1'b0);
        tick();
        check("wdog_halt", a_halted, 1'b1);
        check("wdog_cause", a_cause, 2'b10);
`else
        repeat (40) tick();
        check("nowdog_halted", a_halted, 1'b0);
        check("nowdog_cause", a_cause, 2'b00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tinycpu_monitor.md
TINYCPU_MONITOR -- requirements
Module: tinycpu_monitor

Interface
REQ-001 Parameters SHALL be: DATA_W, 8, register width; ADDR_W, 8, PC width; FIFO_DEPTH, 8, trace entries (power of 2, >=2); LOOP_COUNT, 1, consecutive self-jumps that trigger halt (>=1); WDOG_CYCLES, 100000, idle-cycle timeout (>=2).
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 retire_valid  in  1  one instruction retired this cycle.
REQ-005 retire_pc  in  ADDR_W  address of retired instruction.
REQ-006 retire_jump  in  1  retired instruction was a taken jump.
REQ-007 retire_target  in  ADDR_W  jump destination.
REQ-008 retire_ra, retire_rb, retire_rm  in  DATA_W each  post-retire A, B, M register values.
REQ-009 trace_valid  out  1  trace_data holds an entry.
REQ-010 trace_ready  in  1  consumer accepts entry when trace_valid=1.
REQ-011 trace_data  out  ADDR_W+3*DATA_W  {pc, ra, rb, rm}, pc in MSBs.
REQ-012 halted  out  1  sticky halt flag.
REQ-013 halt_cause  out  2  00 none, 01 self-loop, 10 watchdog, 11 reserved/never driven.
REQ-014 drop_count  out  8  saturating count of entries lost to a full FIFO.

Function
REQ-015 A self-jump SHALL be a retire with retire_jump=1 and retire_target==retire_pc.
REQ-016 Loop counter SHALL increment on each self-jump retire, clear on any other retire, and hold on cycles without a retire.
REQ-017 When the counter reaches LOOP_COUNT, halted and halt_cause=01 SHALL assert on the next rising edge; the triggering retire is still traced.
REQ-018 halted and halt_cause SHALL stay set until reset; the first cause wins; on a same-cycle tie, 01 takes priority over 10.
REQ-019 While halted=1, retire inputs SHALL be ignored: no push, no counter update, no drop_count change.
REQ-020 Each non-ignored retire SHALL push one entry; trace_valid SHALL rise one cycle after a push into an empty FIFO.
REQ-021 A pop SHALL occur on trace_valid&trace_ready; FIFO order is strictly first in, first out.
REQ-022 Push to a full FIFO with no pop SHALL be dropped, and drop_count SHALL increment, saturating at 255.
REQ-023 Push and pop in the same cycle SHALL both succeed, including when the FIFO is full; occupancy is then unchanged.
REQ-024 trace_data SHALL be stable while trace_valid=1 and trace_ready=0.
REQ-025 Read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an extra pointer bit.
REQ-026 The FIFO SHALL keep draining after halt until empty.

Reset
REQ-027 While reset=0, all of the following SHALL clear asynchronously: trace_valid=0, halted=0, halt_cause=00, drop_count=0, FIFO empty, loop and watchdog counters 0.
REQ-028 Reset mid-operation SHALL discard all FIFO contents; trace_data is don't-care while trace_valid=0.
REQ-029 The first retire sampled after reset deasserts SHALL be accepted.

Configuration
REQ-030 Macro TINYCPU_MON_WATCHDOG_EN defined SHALL enable an idle counter: it clears on each retire, increments otherwise, and at WDOG_CYCLES consecutive idle cycles sets halted and halt_cause=10.
REQ-031 Macro TINYCPU_MON_WATCHDOG_EN undefined SHALL remove the idle counter entirely; halt_cause 10 is then never produced.

Structure
REQ-032 Package tinycpu_mon_pkg SHALL hold the halt_cause encodings (HALT_NONE, HALT_LOOP, HALT_WDOG) and the trace field-offset constants.
REQ-033 Trace storage SHALL be a sub-module tinycpu_mon_fifo, parametrised in width and depth, with a valid/ready read side and push/full write side.

Verification
REQ-034 Retire pc=5, jump, target=5 with LOOP_COUNT=1 -> halted=1 and cause=01 next edge; entry {5,...} traced; later retires ignored.
REQ-035 LOOP_COUNT=3, self-jump x2, non-jump, self-jump x3 -> halt only after the third self-jump of the second run.
REQ-036 trace_ready=0, 10 retires at DEPTH=8 -> 8 entries held, drop_count=2; then ready=1 -> 8 entries drain in order.
REQ-037 FIFO full, push+pop same cycle -> no drop, occupancy stays 8, new entry appears last.
REQ-038 With TINYCPU_MON_WATCHDOG_EN defined and WDOG_CYCLES=16, no retires for 16 cycles -> halted=1, cause=10; a retire at cycle 15 restarts the count.
REQ-039 reset=0 pulse mid-stream with 4 entries queued -> trace_valid=0 immediately; drop_count=0; halted=0.
